// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: BCD digit type, decade limits,
// default sizing and the bit positions of the synchronized control inputs.
package freq_meter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam int DIGITS_DEFAULT      = 6;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Bit positions inside the shared synchronizer word.
  localparam int SIG_FX    = 0;
  localparam int SIG_EN    = 1;
  localparam int SIG_CLR   = 2;
  localparam int SIG_LATCH = 3;
  localparam int N_SYNC    = 4;

  // Any code at or above 9 rolls to 0, so a corrupted digit self-heals.
  function automatic bcd_digit_t bcd_next(bcd_digit_t d);
    return (d >= BCD_MAX) ? bcd_digit_t'(0) : bcd_digit_t'(d + 4'd1);
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade of the edge counter: synchronous clear, increment on inc,
// carry_out is combinational (inc while the digit shows 9).
module bcd_decade
  import freq_meter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= bcd_next(digit);
    end
  end

  assign carry_out = inc && (digit == BCD_MAX);

endmodule

// File: rtl/freq_count_latch.sv
// Gated multi-decade BCD edge counter with saturating overflow and a display latch;
// count updates SYNC_STAGES+1 clocks after fx rises. FREQ_COUNT_BLANK_EN adds blank_mask.
module freq_count_latch
  import freq_meter_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fx,
  input  logic                counter_en,
  input  logic                counter_clr,
  input  logic                latch_en,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                ovf_out,
`ifdef FREQ_COUNT_BLANK_EN
  output logic [DIGITS-1:0]   blank_mask,
`endif
  output logic                latch_valid
);

  logic [N_SYNC-1:0] raw_in;
  logic [N_SYNC-1:0] sync_q [SYNC_STAGES];
  logic [N_SYNC-1:0] sync_out;

  logic fx_s, en_s, clr_s, latch_s;
  logic fx_d, latch_d;
  logic fx_rise, latch_rise;

  logic count_req;
  logic all_nines;
  logic inc0;
  logic ovf_q;

  logic [BCD_W-1:0]        digit_q [DIGITS];
  logic [DIGITS-1:0]       inc_c;
  logic [DIGITS-1:0]       carry_c;
  logic [BCD_W*DIGITS-1:0] count_flat;

  // ---------------- input synchronizers ----------------
  always_comb begin
    raw_in            = '0;
    raw_in[SIG_FX]    = fx;
    raw_in[SIG_EN]    = counter_en;
    raw_in[SIG_CLR]   = counter_clr;
    raw_in[SIG_LATCH] = latch_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign fx_s     = sync_out[SIG_FX];
  assign en_s     = sync_out[SIG_EN];
  assign clr_s    = sync_out[SIG_CLR];
  assign latch_s  = sync_out[SIG_LATCH];

  // Only fx and latch_en are edge-triggered; gate and clear act on level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fx_d    <= 1'b0;
      latch_d <= 1'b0;
    end else begin
      fx_d    <= fx_s;
      latch_d <= latch_s;
    end
  end

  assign fx_rise    = fx_s & ~fx_d;
  assign latch_rise = latch_s & ~latch_d;

  // ---------------- counter chain ----------------
  assign count_req = fx_rise & en_s & ~clr_s;

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_nines = all_nines & (digit_q[i] == BCD_MAX);
    end
  end

  // Suppressing the LSD increment at all-9s freezes the whole chain: saturation.
  assign inc0 = count_req & ~all_nines;

  for (genvar g = 0; g < DIGITS; g++) begin : g_decade
    if (g == 0) begin : g_lsd
      assign inc_c[g] = inc0;
    end else begin : g_upper
      assign inc_c[g] = carry_c[g-1];
    end

    bcd_decade u_decade (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_s),
      .inc       (inc_c[g]),
      .digit     (digit_q[g]),
      .carry_out (carry_c[g])
    );

    assign count_flat[BCD_W*g +: BCD_W] = digit_q[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (clr_s) begin
      ovf_q <= 1'b0;
    end else if (count_req && all_nines) begin
      ovf_q <= 1'b1;
    end
  end

  // The saturation gate must keep the most significant carry silent.
  assert property (@(posedge clk) disable iff (rst) !carry_c[DIGITS-1]);

  // ---------------- display latch ----------------
  // Registers are read before this edge's increment/clear lands: pre-update capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out     <= '0;
      ovf_out     <= 1'b0;
      latch_valid <= 1'b0;
    end else begin
      latch_valid <= latch_rise;
      if (latch_rise) begin
        bcd_out <= count_flat;
        ovf_out <= ovf_q;
      end
    end
  end

`ifdef FREQ_COUNT_BLANK_EN
  logic [DIGITS-1:0] blank_next;

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_next = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above    = zero_above & (digit_q[i] == '0);
      blank_next[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_mask <= '0;
    end else if (latch_rise) begin
      blank_mask <= blank_next;
    end
  end
`endif

endmodule

// File: tb/tb_freq_count_latch.sv
// Randomized bench for freq_count_latch: a 6-digit and a 2-digit instance share stimulus
// and are checked against an integer edge-count model with saturation.
module tb_freq_count_latch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fx = 1'b0;
  logic counter_en = 1'b0;
  logic counter_clr = 1'b0;
  logic latch_en = 1'b0;

  logic [23:0] bcd6;
  logic        ovf6, lv6;
  logic [7:0]  bcd2;
  logic        ovf2, lv2;
`ifdef FREQ_COUNT_BLANK_EN
  logic [5:0]  blank6;
  logic [1:0]  blank2;
`endif

  always #10 clk = ~clk;

  freq_count_latch #(.DIGITS(6), .SYNC_STAGES(2)) dut6 (
    .clk(clk), .rst(rst), .fx(fx), .counter_en(counter_en),
    .counter_clr(counter_clr), .latch_en(latch_en),
    .bcd_out(bcd6), .ovf_out(ovf6),
`ifdef FREQ_COUNT_BLANK_EN
    .blank_mask(blank6),
`endif
    .latch_valid(lv6)
  );

  freq_count_latch #(.DIGITS(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .fx(fx), .counter_en(counter_en),
    .counter_clr(counter_clr), .latch_en(latch_en),
    .bcd_out(bcd2), .ovf_out(ovf2),
`ifdef FREQ_COUNT_BLANK_EN
    .blank_mask(blank2),
`endif
    .latch_valid(lv2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain integer edge counts, saturating at 10^DIGITS-1.
  int cnt6 = 0;
  int cnt2 = 0;
  bit mo6 = 1'b0;
  bit mo2 = 1'b0;
  bit gate = 1'b0;

  function automatic logic [23:0] to_bcd(int v);
    logic [23:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] blank_exp(int v, int d);
    logic [5:0] m;
    int p;
    m = '0;
    p = 1;
    for (int i = 1; i < d; i++) begin
      p = p * 10;
      if (v < p) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_edge();
    if (gate) begin
      if (cnt6 == 999999) mo6 = 1'b1; else cnt6++;
      if (cnt2 == 99)     mo2 = 1'b1; else cnt2++;
    end
  endtask

  task automatic model_clear();
    cnt6 = 0; cnt2 = 0; mo6 = 1'b0; mo2 = 1'b0;
  endtask

  task automatic fx_edges(int n);
    for (int k = 0; k < n; k++) begin
      fx = 1'b1;
      model_edge();
      repeat ($urandom_range(2, 3)) @(negedge clk);
      fx = 1'b0;
      repeat ($urandom_range(3, 4)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic set_gate(bit v);
    counter_en = v;
    repeat (6) @(negedge clk);
    gate = v;
  endtask

  task automatic do_clear();
    counter_clr = 1'b1;
    repeat (3) @(negedge clk);
    counter_clr = 1'b0;
    repeat (6) @(negedge clk);
    model_clear();
  endtask

  task automatic do_latch(string name);
    logic [23:0] e6, tmp;
    logic [7:0]  e2;
    int p6, p2;
    e6  = to_bcd(cnt6);
    tmp = to_bcd(cnt2);
    e2  = tmp[7:0];
    p6 = 0; p2 = 0;
    latch_en = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (lv6) p6++;
      if (lv2) p2++;
    end
    latch_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (lv6) p6++;
      if (lv2) p2++;
    end
    n_vec++; if (p6 !== 1) begin n_err++; $display("FAIL %s latch_valid6 pulses: got %0d want 1", name, p6); end
    n_vec++; if (p2 !== 1) begin n_err++; $display("FAIL %s latch_valid2 pulses: got %0d want 1", name, p2); end
    n_vec++; if (bcd6 !== e6) begin n_err++; $display("FAIL %s bcd6: got %h want %h", name, bcd6, e6); end
    n_vec++; if (ovf6 !== mo6) begin n_err++; $display("FAIL %s ovf6: got %b want %b", name, ovf6, mo6); end
    n_vec++; if (bcd2 !== e2) begin n_err++; $display("FAIL %s bcd2: got %h want %h", name, bcd2, e2); end
    n_vec++; if (ovf2 !== mo2) begin n_err++; $display("FAIL %s ovf2: got %b want %b", name, ovf2, mo2); end
`ifdef FREQ_COUNT_BLANK_EN
    begin
      logic [5:0] b6, b2;
      b6 = blank_exp(cnt6, 6);
      b2 = blank_exp(cnt2, 2);
      n_vec++; if (blank6 !== b6) begin n_err++; $display("FAIL %s blank6: got %b want %b", name, blank6, b6); end
      n_vec++; if (blank2 !== b2[1:0]) begin n_err++; $display("FAIL %s blank2: got %b want %b", name, blank2, b2[1:0]); end
    end
`endif
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bcd6 !== 24'h0) begin n_err++; $display("FAIL reset bcd6: got %h want 000000", bcd6); end
    n_vec++; if (ovf6 !== 1'b0) begin n_err++; $display("FAIL reset ovf6: got %b want 0", ovf6); end
    n_vec++; if (lv6 !== 1'b0) begin n_err++; $display("FAIL reset latch_valid6: got %b want 0", lv6); end
    n_vec++; if (bcd2 !== 8'h0) begin n_err++; $display("FAIL reset bcd2: got %h want 00", bcd2); end
    rst = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
    do_latch("reset_latch");
  endtask

  task automatic test_basic();
    do_clear();
    set_gate(1'b1);
    fx_edges(1000);
    set_gate(1'b0);
    do_latch("basic");
    n_vec++; if (bcd6 !== 24'h001000) begin n_err++; $display("FAIL basic_const bcd6: got %h want 001000", bcd6); end
  endtask

  task automatic test_reset_mid();
    set_gate(1'b1);
    fx_edges(25);
    fx = 1'b1;
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    n_vec++; if (bcd6 !== 24'h0) begin n_err++; $display("FAIL reset_mid bcd6: got %h want 000000", bcd6); end
    n_vec++; if (ovf6 !== 1'b0) begin n_err++; $display("FAIL reset_mid ovf6: got %b want 0", ovf6); end
    n_vec++; if (lv6 !== 1'b0) begin n_err++; $display("FAIL reset_mid latch_valid6: got %b want 0", lv6); end
    n_vec++; if (bcd2 !== 8'h0) begin n_err++; $display("FAIL reset_mid bcd2: got %h want 00", bcd2); end
    fx = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (6) @(negedge clk);
    do_latch("after_reset");
    do_clear();
    fx_edges(37);
    do_latch("resume");
    set_gate(1'b0);
  endtask

  task automatic test_decade_carry();
    do_clear();
    set_gate(1'b1);
    fx_edges(999);
    do_latch("carry_999");
    fx_edges(1);
    do_latch("carry_1000");
    set_gate(1'b0);
  endtask

  task automatic test_overflow();
    do_clear();
    set_gate(1'b1);
    fx_edges(105);
    do_latch("ovf_105");
    n_vec++; if (ovf2 !== 1'b1) begin n_err++; $display("FAIL ovf_const ovf2: got %b want 1", ovf2); end
    do_clear();
    fx_edges(3);
    do_latch("ovf_clear_3");
    set_gate(1'b0);
  endtask

  task automatic test_gate_closed();
    set_gate(1'b0);
    fx_edges(50);
    do_latch("gate_closed");
  endtask

  task automatic test_coincidence();
    logic [23:0] e6;
    int p6;
    set_gate(1'b1);
    fx_edges(57);
    set_gate(1'b0);
    e6 = to_bcd(cnt6);
    p6 = 0;
    counter_clr = 1'b1;
    latch_en = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (lv6) p6++;
    end
    counter_clr = 1'b0;
    latch_en = 1'b0;
    repeat (6) @(negedge clk);
    model_clear();
    n_vec++; if (bcd6 !== e6) begin n_err++; $display("FAIL coincide bcd6: got %h want %h", bcd6, e6); end
    n_vec++; if (p6 !== 1) begin n_err++; $display("FAIL coincide pulses: got %0d want 1", p6); end
    do_latch("after_coincide");
  endtask

`ifdef FREQ_COUNT_BLANK_EN
  task automatic test_blank();
    do_clear();
    set_gate(1'b1);
    fx_edges(120);
    set_gate(1'b0);
    do_latch("blank_120");
    n_vec++; if (blank6 !== 6'b111000) begin n_err++; $display("FAIL blank_const: got %b want 111000", blank6); end
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 2) == 0) do_clear();
      set_gate(1'($urandom_range(0, 1)));
      fx_edges($urandom_range(0, 150));
      do_latch("random");
    end
    set_gate(1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_decade_carry();
    test_overflow();
    test_gate_closed();
    test_coincidence();
`ifdef FREQ_COUNT_BLANK_EN
    test_blank();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
